// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token symbols and the decoder alignment FSM encoding.
package tmds_pkg;

  localparam logic [9:0] CtrlTok00 = 10'b1101010100;
  localparam logic [9:0] CtrlTok01 = 10'b0010101011;
  localparam logic [9:0] CtrlTok10 = 10'b0101010100;
  localparam logic [9:0] CtrlTok11 = 10'b1010101011;

  typedef enum logic [1:0] {
    StSearch   = 2'd0,
    StSlipHold = 2'd1,
    StLocked   = 2'd2
  } align_state_e;

  // Encoder-side lookup of the token that carries a pair of control bits.
  function automatic logic [9:0] ctrl_token(input logic [1:0] ctrl);
    logic [9:0] tok;
    case (ctrl)
      2'b00:   tok = CtrlTok00;
      2'b01:   tok = CtrlTok01;
      2'b10:   tok = CtrlTok10;
      default: tok = CtrlTok11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one 10-bit TMDS symbol into a control pair or a video byte.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym_i,
  output logic       is_ctrl_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  logic [7:0] d;

  always_comb begin
    is_ctrl_o = 1'b1;
    ctrl_o    = 2'b00;
    case (sym_i)
      CtrlTok00: ctrl_o = 2'b00;
      CtrlTok01: ctrl_o = 2'b01;
      CtrlTok10: ctrl_o = 2'b10;
      CtrlTok11: ctrl_o = 2'b11;
      default:   is_ctrl_o = 1'b0;
    endcase
  end

  assign d = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];

  // Bit 8 selects the XOR (1) or XNOR (0) transition-minimising chain.
  assign data_o = {d[7:1] ^ d[6:0] ^ {7{~sym_i[8]}}, d[0]};

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: two-stage symbol pipeline plus control-run word-alignment FSM
// that requests bitslips from the deserializer until the control token stream lines up.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SEARCH_WINDOW = 4096,
  parameter int unsigned SLIP_WAIT     = 16
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       aligned,
  output logic       bitslip
);

  localparam int unsigned RunW  = $clog2(CTRL_RUN + 1);
  localparam int unsigned WinW  = $clog2(SEARCH_WINDOW + 1);
  localparam int unsigned SlipW = $clog2(SLIP_WAIT + 1);

  localparam logic [RunW-1:0]  RunMax  = RunW'(CTRL_RUN);
  localparam logic [WinW-1:0]  WinMax  = WinW'(SEARCH_WINDOW);
  localparam logic [SlipW-1:0] SlipMax = SlipW'(SLIP_WAIT);

  logic [9:0]       sym_q;
  logic             dec_is_ctrl;
  logic [1:0]       dec_ctrl;
  logic [7:0]       dec_data;
  logic [7:0]       data_q;
  logic [1:0]       ctrl_q;
  logic             de_q;
  align_state_e     state_q, state_d;
  logic [RunW-1:0]  run_q, run_d, run_inc;
  logic [WinW-1:0]  win_q, win_d, win_inc;
  logic [SlipW-1:0] slip_q, slip_d, slip_inc;
  logic             run_hit, win_expire;

  tmds_symbol_decode u_symbol_decode (
    .sym_i     (sym_q),
    .is_ctrl_o (dec_is_ctrl),
    .ctrl_o    (dec_ctrl),
    .data_o    (dec_data)
  );

  always_comb begin
    run_inc    = (run_q == RunMax) ? run_q : run_q + RunW'(1);
    win_inc    = (win_q == WinMax) ? win_q : win_q + WinW'(1);
    slip_inc   = (slip_q == SlipMax) ? slip_q : slip_q + SlipW'(1);
    run_hit    = dec_is_ctrl && (run_inc == RunMax);
    win_expire = (win_inc == WinMax);
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    win_d   = win_q;
    slip_d  = slip_q;
    bitslip = 1'b0;
    case (state_q)
      StSearch, StLocked: begin
        run_d = dec_is_ctrl ? run_inc : '0;
        // A completed run outranks window expiry, so a late lock never slips.
        if (run_hit) begin
          state_d = StLocked;
          win_d   = '0;
        end else if (win_expire) begin
          win_d = '0;
          if (state_q == StSearch) begin
            state_d = StSlipHold;
            bitslip = 1'b1;
          end else begin
            state_d = StSearch;
          end
        end else begin
          win_d = win_inc;
        end
      end
      StSlipHold: begin
        run_d = '0;
        if (slip_inc == SlipMax) begin
          state_d = StSearch;
          slip_d  = '0;
        end else begin
          slip_d = slip_inc;
        end
      end
      default: begin
        state_d = StSearch;
        run_d   = '0;
        win_d   = '0;
        slip_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      sym_q   <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      de_q    <= 1'b0;
      state_q <= StSearch;
      run_q   <= '0;
      win_q   <= '0;
      slip_q  <= '0;
    end else begin
      sym_q   <= tmds_in;
      state_q <= state_d;
      run_q   <= run_d;
      win_q   <= win_d;
      slip_q  <= slip_d;
      if (dec_is_ctrl) begin
        ctrl_q <= dec_ctrl;
      end else begin
        data_q <= dec_data;
      end
      // Qualify with the next state so de_out and aligned change on the same edge.
      de_q <= ~dec_is_ctrl & (state_d == StLocked);
    end
  end

  assign data_out = data_q;
  assign ctrl_out = ctrl_q;
  assign de_out   = de_q;
  assign aligned  = (state_q == StLocked);

endmodule

// File: tb/tb_tmds_decoder.sv
// Randomised bench for tmds_decoder against a rule-level model of decode and alignment.
module tb_tmds_decoder;

  localparam int unsigned CR    = 8;
  localparam int unsigned SW    = 64;
  localparam int unsigned SWAIT = 16;

  localparam int MSearch = 0;
  localparam int MHold   = 1;
  localparam int MLocked = 2;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [9:0] tmds_in;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       aligned;
  logic       bitslip;

  tmds_decoder #(
    .CTRL_RUN      (CR),
    .SEARCH_WINDOW (SW),
    .SLIP_WAIT     (SWAIT)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .tmds_in   (tmds_in),
    .data_out  (data_out),
    .ctrl_out  (ctrl_out),
    .de_out    (de_out),
    .aligned   (aligned),
    .bitslip   (bitslip)
  );

  always #5 clk_pixel = ~clk_pixel;

  logic [9:0] toks [4] = '{T00, T01, T10, T11};

  int total;
  int bad;
  int cyc;
  int slip_cyc[$];
  bit prev_bs;

  // Model state
  int         m_mode, m_streak, m_win, m_hold;
  bit         s1_tok, s1_known;
  logic [1:0] s1_ctrl;
  logic [7:0] s1_byte;
  logic [7:0] e_data;
  bit         e_known;
  logic [1:0] e_ctrl;
  bit         e_de;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit tok_of(input logic [9:0] s, output logic [1:0] c);
    c = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (s == toks[k]) begin
        c = 2'(k);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // DVI encoder with the path and inversion forced by the caller.
  function automatic logic [9:0] enc(input logic [7:0] b, input bit use_xnor, input bit inv);
    logic [7:0] q;
    q[0] = b[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ b[i]) : (q[i-1] ^ b[i]);
    return {inv, ~use_xnor, inv ? ~q : q};
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] s, input int r);
    logic [9:0] t;
    t = s;
    for (int i = 0; i < r; i++) t = {t[8:0], t[9]};
    return t;
  endfunction

  task automatic model_reset();
    m_mode   = MSearch;
    m_streak = 0;
    m_win    = 0;
    m_hold   = 0;
    // Stage 1 holds symbol 0 after reset: XNOR path of all zeros is 8'hFE.
    s1_tok   = 1'b0;
    s1_ctrl  = 2'b00;
    s1_byte  = 8'hFE;
    s1_known = 1'b1;
    e_data   = 8'h00;
    e_known  = 1'b1;
    e_ctrl   = 2'b00;
    e_de     = 1'b0;
    prev_bs  = 1'b0;
  endtask

  task automatic fsm_step(input bit tok);
    if (m_mode == MHold) begin
      m_streak = 0;
      m_hold++;
      if (m_hold == SWAIT) begin
        m_mode = MSearch;
        m_hold = 0;
      end
    end else begin
      m_streak = tok ? ((m_streak < CR) ? m_streak + 1 : CR) : 0;
      if (m_streak == CR) begin
        m_mode = MLocked;
        m_win  = 0;
      end else begin
        m_win++;
        if (m_win == SW) begin
          m_win  = 0;
          m_mode = (m_mode == MSearch) ? MHold : MSearch;
        end
      end
    end
  endtask

  task automatic step(input logic [9:0] sym, input bit known, input logic [7:0] b);
    logic [1:0] c;
    bit         tk;
    bit         e_bs;
    tmds_in = sym;
    @(posedge clk_pixel);
    if (s1_tok) begin
      e_ctrl = s1_ctrl;
    end else begin
      e_data  = s1_byte;
      e_known = s1_known;
    end
    fsm_step(s1_tok);
    e_de     = !s1_tok && (m_mode == MLocked);
    tk       = tok_of(sym, c);
    s1_tok   = tk;
    s1_ctrl  = c;
    s1_byte  = b;
    s1_known = known;
    #1;
    cyc++;
    e_bs = (m_mode == MSearch) && !(s1_tok && (m_streak + 1 >= CR)) && (m_win + 1 >= SW);
    if (e_known) check_eq("data_out", 32'(data_out), 32'(e_data));
    check_eq("ctrl_out", 32'(ctrl_out), 32'(e_ctrl));
    check_eq("de_out", 32'(de_out), 32'(e_de));
    check_eq("aligned", 32'(aligned), 32'(m_mode == MLocked));
    check_eq("bitslip", 32'(bitslip), 32'(e_bs));
    if (prev_bs) check_eq("bitslip_twice", 32'(bitslip), 32'd0);
    if (bitslip) slip_cyc.push_back(cyc);
    prev_bs = bitslip;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_ctrl", 32'(ctrl_out), 32'd0);
    check_eq("rst_de", 32'(de_out), 32'd0);
    check_eq("rst_aligned", 32'(aligned), 32'd0);
    check_eq("rst_bitslip", 32'(bitslip), 32'd0);
    @(negedge clk_pixel);
    reset = 1'b0;
    model_reset();
    #1 check_eq("rel_bitslip", 32'(bitslip), 32'd0);
  endtask

  task automatic video(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      step(enc(b, 1'($urandom), 1'($urandom)), 1'b1, b);
    end
  endtask

  task automatic tokens(input int n);
    for (int i = 0; i < n; i++) step(toks[$urandom_range(3)], 1'b0, 8'h00);
  endtask

  initial begin
    int n;
    int rot;
    int s0;
    int last_slip;
    total   = 0;
    bad     = 0;
    cyc     = 0;
    reset   = 1'b1;
    tmds_in = 10'd0;
    model_reset();
    do_reset();

    // Initial lock on a blanking run of T00, then video.
    for (int i = 0; i < CR; i++) step(T00, 1'b0, 8'h00);
    check_eq("pre_lock", 32'(aligned), 32'd0);
    video(1);
    check_eq("lock_8th", 32'(aligned), 32'd1);
    video(20);

    // Loopback of every byte on both chains, refreshing lock with control runs.
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 256; b++) begin
        if ((b % 48) == 0) tokens(CR);
        step(enc(8'(b), 1'(p), 1'($urandom)), 1'b1, 8'(b));
      end
    end
    video(2);

    // Reset while locked, then re-lock.
    tokens(CR);
    video(1);
    check_eq("locked_before_rst", 32'(aligned), 32'd1);
    do_reset();
    tokens(CR);
    video(2);
    check_eq("relock_after_rst", 32'(aligned), 32'd1);

    // Lock loss after a window of pure video.
    tokens(CR);
    n = 0;
    while (aligned && n < 3 * SW) begin
      video(1);
      n++;
    end
    check_eq("unlock_steps", 32'(n), 32'(SW + 1));
    check_eq("unlock_bitslip", 32'(bitslip), 32'd0);

    // Reset during a bitslip pulse.
    n = 0;
    while (!bitslip && n < 3 * SW) begin
      video(1);
      n++;
    end
    check_eq("pulse_seen", 32'(bitslip), 32'd1);
    do_reset();
    tokens(CR);
    video(2);
    check_eq("relock_after_pulse_rst", 32'(aligned), 32'd1);

    // Run completion coincides with window expiry.
    do_reset();
    s0 = slip_cyc.size();
    n  = 0;
    while (m_win < int'(SW - 1 - CR) && n < 2 * SW) begin
      video(1);
      n++;
    end
    for (int i = 0; i < CR; i++) step(T01, 1'b0, 8'h00);
    video(1);
    check_eq("coincide_lock", 32'(aligned), 32'd1);
    check_eq("coincide_noslip", 32'(slip_cyc.size() - s0), 32'd0);

    // Bit-rotated control stream: slips until the rotation is undone.
    do_reset();
    rot = 3;
    s0  = slip_cyc.size();
    n   = 0;
    while (!aligned && n < 1000) begin
      step(rotl(T00, rot), 1'b0, 8'h00);
      if (bitslip && rot > 0) rot--;
      n++;
    end
    check_eq("rot_lock", 32'(aligned), 32'd1);
    check_eq("rot_slips", 32'(slip_cyc.size() - s0), 32'd3);
    if (slip_cyc.size() - s0 == 3) begin
      check_eq("rot_gap1", 32'(slip_cyc[s0+1] - slip_cyc[s0]), 32'(SW + SWAIT));
      check_eq("rot_gap2", 32'(slip_cyc[s0+2] - slip_cyc[s0+1]), 32'(SW + SWAIT));
      last_slip = slip_cyc[s0+2];
      check_eq("rot_lock_delay", 32'(cyc - last_slip), 32'(SWAIT + CR + 1));
    end
    video(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 Parameter CTRL_RUN, default 8, is the number of consecutive control tokens that declares word alignment.
REQ-002 Parameter SEARCH_WINDOW, default 4096, is the number of cycles without a qualifying control run before a bitslip, or before lock is lost.
REQ-003 Parameter SLIP_WAIT, default 16, is the number of idle cycles after each bitslip pulse while the deserializer settles.
REQ-004 Ports SHALL be:
- clk_pixel  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- tmds_in  in  10  deserialized TMDS symbol, one per clk_pixel, bit 0 first on the wire.
- data_out  out  8  decoded video byte.
- ctrl_out  out  2  decoded control bits {c1,c0}; for channel 0 this is {vsync,hsync}.
- de_out  out  1  video data enable.
- aligned  out  1  word alignment locked.
- bitslip  out  1  one-cycle request to the deserializer to shift the word boundary by one bit.

Function
REQ-005 tmds_in SHALL be registered at stage 1; decode results SHALL be registered at stage 2, giving a latency of exactly 2 clk_pixel cycles from tmds_in to data_out, ctrl_out and de_out.
REQ-006 Control tokens SHALL decode as follows: 10'b1101010100 gives ctrl 2'b00, 10'b0010101011 gives 2'b01, 10'b0101010100 gives 2'b10, and 10'b1010101011 gives 2'b11.
REQ-007 On a control token, de_out SHALL be 0, ctrl_out SHALL take the decoded value, and data_out SHALL hold its previous value.
REQ-008 Any non-token symbol SHALL decode as video data:
- d = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0].
- data_out[0] = d[0].
- For i = 1..7: data_out[i] = d[i]^d[i-1] when tmds_in[8] = 1, otherwise ~(d[i]^d[i-1]).
- de_out = 1 and ctrl_out holds its previous value.
REQ-009 When aligned = 0, de_out SHALL be forced to 0; data_out and ctrl_out SHALL still update per REQ-006 to REQ-008.
REQ-010 The alignment FSM SHALL have three states: SEARCH, SLIP_HOLD and LOCKED; its reset state SHALL be SEARCH.
REQ-011 run_cnt SHALL increment on each stage-1 control token, clear on each non-token, and saturate at CTRL_RUN.
REQ-012 win_cnt SHALL increment every cycle in SEARCH and LOCKED, clear on every state transition and whenever run_cnt reaches CTRL_RUN, and saturate at SEARCH_WINDOW.
REQ-013 SEARCH SHALL transition as follows:
- run_cnt reaching CTRL_RUN goes to LOCKED.
- Otherwise, win_cnt reaching SEARCH_WINDOW pulses bitslip high for exactly one cycle and goes to SLIP_HOLD.
REQ-014 SLIP_HOLD SHALL ignore tmds_in, hold run_cnt at 0, count SLIP_WAIT cycles, then return to SEARCH.
REQ-015 LOCKED SHALL drive aligned = 1 and SHALL return to SEARCH, with aligned = 0 and no bitslip pulse, when win_cnt reaches SEARCH_WINDOW without a new CTRL_RUN run.
REQ-016 If run completion and window expiry occur in the same cycle, run completion SHALL win: go to or stay in LOCKED, with no bitslip.
REQ-017 bitslip SHALL never be asserted in LOCKED or SLIP_HOLD, and SHALL never be high in two consecutive cycles.
REQ-018 Counter widths SHALL be $clog2(param+1) bits, and no counter SHALL wrap.

Reset
REQ-019 Asserting reset SHALL immediately clear the following regardless of the clock: data_out = 0, ctrl_out = 0, de_out = 0, aligned = 0, bitslip = 0, both pipeline stages = 0, all counters = 0, and FSM = SEARCH.
REQ-020 Reset asserted mid-operation, including in LOCKED or during a bitslip pulse, SHALL abort the operation, and no bitslip SHALL be emitted in the cycle reset deasserts.

Structure
REQ-021 The four control-token constants and the FSM state encoding SHALL live in the shared package tmds_pkg, which is also used by the encoder side.
REQ-022 The combinational symbol decode (REQ-006 to REQ-008) SHALL be a sub-module named tmds_symbol_decode; the FSM and counters SHALL stay in tmds_decoder.

Verification
REQ-023 After reset, drive 10'b1101010100 for 8 cycles, then video symbols -> aligned rises on the 8th token; later de_out = 1 with correct bytes 2 cycles after each symbol.
REQ-024 Encoder-to-decoder loopback through tmds_channel over all 256 byte values in both XOR and XNOR paths -> data_out equals the original byte 2 cycles later, with no mismatches.
REQ-025 Drive a bit-rotated control stream -> bitslip pulses every SEARCH_WINDOW+SLIP_WAIT cycles until the rotation is undone, then aligned = 1 after CTRL_RUN tokens.
REQ-026 In LOCKED, feed only video symbols for SEARCH_WINDOW cycles -> aligned falls to 0 with no bitslip in that cycle, and the FSM is in SEARCH.
REQ-027 Make the CTRL_RUN-th token coincide with win_cnt = SEARCH_WINDOW -> LOCKED is entered and bitslip stays 0.
REQ-028 Assert reset while in LOCKED and mid-pulse -> all outputs are 0 immediately, and after release the FSM re-locks from SEARCH.
